pulp_clock_gate_ctrl: RTL

Multi-channel automatic clock-gate controller that produces the enable inputs for per-channel latch-based clock gating cells. Each channel runs its own idle-detect FSM: after a programmable number of consecutive idle cycles the channel's enable drops, and it is restored on activity, force or a wake request. A wake handshake tells the requester when its clock is running again. The block sits in the SoC clock/power control domain, on the ungated clock, between peripheral busy/request signals and the gate cells.

---
 rtl/pulp_clock_gate_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/pulp_clock_gate_ctrl.sv
// Multi-channel automatic clock-gate controller.
// Each channel gates its clock after a run of idle cycles and reopens on demand.
module pulp_clock_gate_ctrl #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned WAKE_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              test_en_i,
   input  logic [CNT_W-1:0]  idle_thr_i,
   input  logic [NUM_CH-1:0] auto_en_i,
   input  logic [NUM_CH-1:0] force_on_i,
   input  logic [NUM_CH-1:0] busy_i,
   input  logic [NUM_CH-1:0] wake_req_i,
   output logic [NUM_CH-1:0] wake_ack_o,
   output logic [NUM_CH-1:0] clk_en_o,
   output logic [NUM_CH-1:0] gated_o,
   output logic              all_gated_o
);

   localparam int unsigned WW =
      (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;
   localparam logic [WW-1:0] W_LAST =
      WW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_ON,
      ST_COUNT,
      ST_OFF,
      ST_WAKE
   } state_e;

   logic              gate_ok;
   logic [NUM_CH-1:0] idle;

   assign gate_ok = ~test_en_i & (|idle_thr_i);
   assign idle    = auto_en_i & ~busy_i & ~force_on_i & ~wake_req_i
                  & {NUM_CH{gate_ok}};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_e            state_q, state_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
      logic [WW-1:0]     wcnt_q, wcnt_d;

      always_ff @(posedge clk_i) begin
         if (!rst_ni) begin
            state_q <= ST_ON;
            cnt_q   <= '0;
            wcnt_q  <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
         end
      end

      // Saturating increment; threshold is compared live every cycle
      assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         wcnt_d  = wcnt_q;
         unique case (state_q)
            ST_ON, ST_COUNT: begin
               if (idle[g]) begin
                  if (cnt_inc >= idle_thr_i) begin
                     state_d = ST_OFF;
                     cnt_d   = '0;
                  end else begin
                     state_d = ST_COUNT;
                     cnt_d   = cnt_inc;
                  end
               end else begin
                  state_d = ST_ON;
                  cnt_d   = '0;
               end
            end
            ST_OFF: begin
               cnt_d = '0;
               if (!idle[g]) begin
                  wcnt_d  = '0;
                  state_d = (WAKE_CYCLES == 0) ? ST_ON : ST_WAKE;
               end
            end
            ST_WAKE: begin
               if (wcnt_q == W_LAST) begin
                  state_d = ST_ON;
                  wcnt_d  = '0;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_ON;
               cnt_d   = '0;
               wcnt_d  = '0;
            end
         endcase
      end

      assign clk_en_o[g]   = (state_q != ST_OFF) | test_en_i;
      assign gated_o[g]    = (state_q == ST_OFF);
      assign wake_ack_o[g] = (state_q == ST_ON) & wake_req_i[g];
   end

   assign all_gated_o = &gated_o;

endmodule
